vram_zoom_writer: RTL and testbench

Fills the video RAM (VdRam) with a scaled copy of the 160×120 source image, at the zoom level chosen by the control FSM. It is the write-side counterpart of the VGA read path, which reads VdRam row-major with stride equal to the output width. On each start pulse it walks every output pixel once, fetches the nearest-neighbour source pixel from the image ROM, and streams one VdRam write per cycle.

---
 rtl/vram_pkg.sv | 24 ++
 rtl/zoom_geometry.sv | 34 +++
 rtl/vram_zoom_writer.sv | 130 +++++++++++++
 tb/tb_vram_zoom_writer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants and zoom encoding for the VdRam zoom writer
package vram_pkg;

  localparam int SRC_W   = 160;
  localparam int SRC_H   = 120;
  localparam int PIX_W   = 8;
  localparam int VRAM_AW = 17;
  localparam int ROM_AW  = 15;
  localparam int DIM_W   = 9;

  typedef enum logic [2:0] {
    ZOOM_QUARTER = 3'd0,
    ZOOM_HALF    = 3'd1,
    ZOOM_NATIVE  = 3'd2,
    ZOOM_DOUBLE  = 3'd3
  } zoom_e;

  // Output geometry per zoom code; codes above ZOOM_DOUBLE reuse its row.
  localparam logic [DIM_W-1:0] ZOOM_W [4] = '{9'd40, 9'd80, 9'd160, 9'd320};
  localparam logic [DIM_W-1:0] ZOOM_H [4] = '{9'd30, 9'd60, 9'd120, 9'd240};
  localparam logic [3:0]       ZOOM_UPSCALE = 4'b1000;
  localparam logic [1:0]       ZOOM_SHIFT [4] = '{2'd2, 2'd1, 2'd0, 2'd1};

endpackage

// File: rtl/zoom_geometry.sv
// rtl/zoom_geometry.sv - maps a latched zoom code to output size and source shift
module zoom_geometry
  import vram_pkg::*;
#(
  parameter int SRC_W = vram_pkg::SRC_W,
  parameter int SRC_H = vram_pkg::SRC_H
) (
  input  logic [2:0]       zoom,
  output logic [DIM_W-1:0] out_w,
  output logic [DIM_W-1:0] out_h,
  output logic             upscale,
  output logic [1:0]       shift_amt
);

  logic [1:0] idx;

  always_comb begin
    idx = 2'd3;
    case (zoom)
      ZOOM_QUARTER: idx = 2'd0;
      ZOOM_HALF:    idx = 2'd1;
      ZOOM_NATIVE:  idx = 2'd2;
      default:      idx = 2'd3;
    endcase
  end

  assign upscale   = ZOOM_UPSCALE[idx];
  assign shift_amt = ZOOM_SHIFT[idx];

  // upscale: output = source << shift, source index = output >> shift
  assign out_w = upscale ? DIM_W'(SRC_W << shift_amt) : DIM_W'(SRC_W >> shift_amt);
  assign out_h = upscale ? DIM_W'(SRC_H << shift_amt) : DIM_W'(SRC_H >> shift_amt);

endmodule

// File: rtl/vram_zoom_writer.sv
// rtl/vram_zoom_writer.sv - fills VdRam with a nearest-neighbour scaled copy of the source image
module vram_zoom_writer
  import vram_pkg::*;
#(
  parameter int SRC_W = vram_pkg::SRC_W,
  parameter int SRC_H = vram_pkg::SRC_H,
  parameter int PIX_W = vram_pkg::PIX_W
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         zoom_level,
  output logic [ROM_AW-1:0]  src_addr,
  input  logic [PIX_W-1:0]   src_data,
  output logic               wr_en,
  output logic [VRAM_AW-1:0] wr_addr,
  output logic [PIX_W-1:0]   wr_data,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state;
  logic [2:0]         zoom_q;
  logic [DIM_W-1:0]   x, y, nx, ny, sx_n, y_mask;
  logic [DIM_W-1:0]   geo_w, geo_h;
  logic               upscale;
  logic [1:0]         shift_amt;
  logic [ROM_AW-1:0]  row_base, row_step, nrow;
  logic               last_x, last_y;
  logic               s1_valid, s2_valid, flush_cnt;
  logic [VRAM_AW-1:0] wr_cnt;

  zoom_geometry #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H)
  ) u_geom (
    .zoom      (zoom_q),
    .out_w     (geo_w),
    .out_h     (geo_h),
    .upscale   (upscale),
    .shift_amt (shift_amt)
  );

  // Next pixel in raster order; the row base only moves when the source row changes.
  always_comb begin
    last_x   = (x == geo_w - 1'b1);
    last_y   = (y == geo_h - 1'b1);
    nx       = last_x ? '0 : x + 1'b1;
    ny       = last_x ? y + 1'b1 : y;
    y_mask   = DIM_W'((1 << shift_amt) - 1);
    row_step = '0;
    if (last_x) begin
      if (!upscale)
        row_step = ROM_AW'(SRC_W << shift_amt);
      else if ((ny & y_mask) == '0)
        row_step = ROM_AW'(SRC_W);
    end
    nrow = row_base + row_step;
    sx_n = upscale ? (nx >> shift_amt) : (nx << shift_amt);
  end

  assign busy = (state == ST_RUN) || (state == ST_FLUSH);
  assign done = (state == ST_DONE);

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      zoom_q    <= '0;
      x         <= '0;
      y         <= '0;
      row_base  <= '0;
      src_addr  <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      flush_cnt <= 1'b0;
      wr_cnt    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      s1_valid <= 1'b0;
      s2_valid <= s1_valid;
      wr_en    <= s2_valid;
      if (s2_valid) begin
        wr_addr <= wr_cnt;
        wr_data <= src_data;
        wr_cnt  <= wr_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            zoom_q   <= zoom_level;
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            src_addr <= '0;
            wr_cnt   <= '0;
            s1_valid <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last_x && last_y) begin
            flush_cnt <= 1'b0;
            state     <= ST_FLUSH;
          end else begin
            x        <= nx;
            y        <= ny;
            row_base <= nrow;
            src_addr <= nrow + ROM_AW'(sx_n);
            s1_valid <= 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt)
            state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_zoom_writer.sv
// tb/tb_vram_zoom_writer.sv - scoreboard bench for vram_zoom_writer
module tb_vram_zoom_writer;

  logic        pclk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  zoom_level = 3'd0;
  logic [14:0] src_addr;
  logic [7:0]  src_data = 8'd0;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [24:0] sb_q[$];

  vram_zoom_writer dut (
    .pclk       (pclk),
    .reset      (reset),
    .start      (start),
    .zoom_level (zoom_level),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  always #10 pclk = ~pclk;

  // Synchronous image ROM with a content that mixes both address bytes.
  always @(posedge pclk)
    src_data <= src_addr[7:0] ^ {1'b0, src_addr[14:8]};

  function automatic logic [24:0] exp_pair(input int z, input int i);
    int e, w, px, py, sx, sy, a;
    logic [7:0] d;
    e  = (z > 3) ? 3 : z;
    w  = 40 << e;
    px = i % w;
    py = i / w;
    if (e == 3) begin
      sx = px >> 1;
      sy = py >> 1;
    end else begin
      sx = px << (2 - e);
      sy = py << (2 - e);
    end
    a = sy * 160 + sx;
    d = 8'(a) ^ 8'(a >> 8);
    return {17'(i), d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_src_addr"}, 32'(src_addr), 32'd0);
    check({tag, "_wr_en"},    32'(wr_en),    32'd0);
    check({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
    check({tag, "_wr_data"},  32'(wr_data),  32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
  endtask

  // Runs one fill; abort_at>0 asserts reset right after that many writes.
  task automatic run_fill(input int z, input int abort_at, input bit disturb);
    int e, n, k, writes, first_k, last_k;
    bit busy_ok, quiet, fin;
    e = (z > 3) ? 3 : z;
    n = (40 << e) * (30 << e);
    for (int i = 0; i < n; i++) sb_q.push_back(exp_pair(z, i));
    @(negedge pclk);
    start = 1'b1;
    zoom_level = 3'(z);
    @(posedge pclk);
    #1 start = 1'b0;
    k = 0; writes = 0; first_k = -1; last_k = -1; busy_ok = 1'b1; fin = 1'b0;
    while (!fin) begin
      @(negedge pclk);
      if (k == 0) check("first_src_addr", 32'(src_addr), 32'd0);
      if (disturb && k == 10) begin
        start = 1'b1;
        zoom_level = 3'(z) ^ 3'd3;
      end
      if (disturb && k == 11) start = 1'b0;
      if (k <= n + 1 && busy !== 1'b1) busy_ok = 1'b0;
      if (wr_en) begin
        writes++;
        if (first_k < 0) first_k = k;
        last_k = k;
        if (sb_q.size() == 0) check("unexpected_write", 32'(sb_q.size()), 32'd1);
        else check("wr_pair", 32'({wr_addr, wr_data}), 32'(sb_q.pop_front()));
      end
      if (abort_at != 0 && writes == abort_at) begin
        reset = 1'b0;
        #1;
        check_idle_outputs("in_reset");
        quiet = 1'b1;
        repeat (4) begin
          @(negedge pclk);
          if (wr_en !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        reset = 1'b1;
        repeat (12) begin
          @(negedge pclk);
          if (wr_en !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("quiet_after_reset", 32'(quiet), 32'd1);
        check("first_write_edge", 32'(first_k), 32'd2);
        fin = 1'b1;
      end else if (done) begin
        check("done_edge",   32'(k),       32'(n + 2));
        check("busy_at_done", 32'(busy),   32'd0);
        check("write_count", 32'(writes),  32'(n));
        check("first_write_edge", 32'(first_k), 32'd2);
        check("last_write_edge",  32'(last_k),  32'(n + 1));
        check("busy_window", 32'(busy_ok), 32'd1);
        @(negedge pclk);
        check("done_one_cycle", 32'(done), 32'd0);
        fin = 1'b1;
      end else if (k > n + 8) begin
        check("done_timeout", 32'(done), 32'd1);
        fin = 1'b1;
      end
      k++;
    end
    sb_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    check_idle_outputs("reset");
    reset = 1'b1;
    repeat (3) @(negedge pclk);
    check("idle_busy", 32'(busy), 32'd0);

    run_fill(2, 300, 1'b0);
    run_fill(3, 100, 1'b0);
    run_fill(0, 0, 1'b0);
    run_fill(1, 0, 1'b1);
    run_fill(5, 0, 1'b0);
    run_fill(0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
